// File: rtl/mem_refill_ctrl.sv
// Miss-handling controller: shares one memory word port between I-cache
// refills and D-cache writeback/refill, sequences word bursts and produces
// the pipeline advance enable.
module mem_refill_ctrl #(
  parameter int WORDS = 4,
  parameter int IDXW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            imiss,
  input  logic [29:0]     imiss_addr,
  input  logic            dmiss,
  input  logic [29:0]     dmiss_addr,
  input  logic            ddirty,
  input  logic [29:0]     dvictim_addr,
  input  logic [31:0]     dvictim_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [29:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic [IDXW-1:0] fill_idx,
  output logic [31:0]     fill_data,
  output logic            ifill_we,
  output logic            dfill_we,
  output logic            itag_we,
  output logic            dtag_we,
  output logic            pipe_en,
  output logic            busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_WB   = 3'd1,
    D_FILL = 3'd2,
    I_FILL = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [29:IDXW]  base_q, base_d;
  logic            last_word;

  // Word-in-block bits of the miss/victim addresses are replaced by cnt.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imiss_addr[IDXW-1:0], dmiss_addr[IDXW-1:0],
                              dvictim_addr[IDXW-1:0]};

  assign last_word = (cnt_q == LAST);

  // Address and data pass-throughs decoded from registered state only.
  assign mem_addr  = {base_q, cnt_q};
  assign mem_wdata = dvictim_data;
  assign fill_data = mem_rdata;
  assign fill_idx  = cnt_q;
  assign busy      = (state_q != IDLE);
  assign pipe_en   = (state_q == IDLE) & ~imiss & ~dmiss;

  // State, word counter and latched block base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  // Next-state, counter/base update and per-state memory/strobe outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    dfill_we = 1'b0;
    ifill_we = 1'b0;
    dtag_we  = 1'b0;
    itag_we  = 1'b0;
    case (state_q)
      IDLE: begin
        // D side first: it belongs to the older instruction.
        if (dmiss && ddirty) begin
          state_d = D_WB;
          base_d  = dvictim_addr[29:IDXW];
          cnt_d   = '0;
        end else if (dmiss) begin
          state_d = D_FILL;
          base_d  = dmiss_addr[29:IDXW];
          cnt_d   = '0;
        end else if (imiss) begin
          state_d = I_FILL;
          base_d  = imiss_addr[29:IDXW];
          cnt_d   = '0;
        end
      end
      D_WB: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (last_word) begin
            // Victim written out; switch the base to the missing block.
            state_d = D_FILL;
            base_d  = dmiss_addr[29:IDXW];
          end
        end
      end
      D_FILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          dfill_we = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (last_word) begin
            dtag_we = 1'b1;
            state_d = DONE;
          end
        end
      end
      I_FILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ifill_we = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (last_word) begin
            itag_we = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Self-checking bench for mem_refill_ctrl: scenario table plus reset and
// spurious-ack sequences, with a transfer scoreboard checked on every ack.
module tb_mem_refill_ctrl;

  localparam int WORDS = 4;
  localparam int IDXW  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imiss, dmiss, ddirty;
  logic [29:0]     imiss_addr, dmiss_addr, dvictim_addr;
  logic [31:0]     dvictim_data;
  logic            mem_req, mem_we, mem_ack;
  logic [29:0]     mem_addr;
  logic [31:0]     mem_wdata, mem_rdata, fill_data;
  logic [IDXW-1:0] fill_idx;
  logic            ifill_we, dfill_we, itag_we, dtag_we, pipe_en, busy;

  always #5 clk = ~clk;

  mem_refill_ctrl #(.WORDS(WORDS), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .imiss(imiss), .imiss_addr(imiss_addr),
    .dmiss(dmiss), .dmiss_addr(dmiss_addr),
    .ddirty(ddirty), .dvictim_addr(dvictim_addr), .dvictim_data(dvictim_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fill_idx(fill_idx), .fill_data(fill_data),
    .ifill_we(ifill_we), .dfill_we(dfill_we),
    .itag_we(itag_we), .dtag_we(dtag_we),
    .pipe_en(pipe_en), .busy(busy)
  );

  // Memory and victim-line models.
  function automatic logic [31:0] rdata_model(input logic [29:0] a);
    return {2'b10, a} ^ 32'h1357_9BDF;
  endfunction
  function automatic logic [31:0] victim_model(input logic [IDXW-1:0] i);
    return 32'hD1C7_0000 | 32'(i);
  endfunction

  assign mem_rdata    = rdata_model(mem_addr);
  assign dvictim_data = victim_model(fill_idx);

  typedef struct {
    logic [29:0] addr;
    bit          we;
    int          kind;  // 0 writeback, 1 D refill, 2 I refill
    bit          last;
  } xfer_t;

  typedef struct {
    string       name;
    bit          im, dm, dirty;
    logic [29:0] ia, da, va;
    int          period;
    int          acks, dtags, itags, dfills, ifills;
  } vec_t;

  xfer_t exp_q[$];
  vec_t  vecs[6];

  int checks = 0, failures = 0;
  int n_acks, n_dtag, n_itag, n_dfill, n_ifill;
  int period = 1, stall = 0;
  bit saw_dtag = 0, saw_itag = 0, spurious = 0, prev_hold = 0;
  logic [29:0] prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_block(input int kind, input logic [29:0] a);
    xfer_t x;
    for (int unsigned i = 0; i < WORDS; i++) begin
      x.addr = {a[29:IDXW], IDXW'(i)};
      x.we   = (kind == 0);
      x.kind = kind;
      x.last = (i == WORDS - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic clear_counts();
    n_acks = 0; n_dtag = 0; n_itag = 0; n_dfill = 0; n_ifill = 0;
  endtask

  // Scoreboard/monitor, sampled away from the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 0;
    end else begin
      if (mem_req && mem_ack) begin
        n_acks++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer: got addr 0x%0h we %0b, required none", mem_addr, mem_we);
        end else begin
          xfer_t e;
          e = exp_q.pop_front();
          check("xfer_addr", 32'(mem_addr), 32'(e.addr));
          check("xfer_we", 32'(mem_we), 32'(e.we));
          check("fill_idx", 32'(fill_idx), 32'(e.addr[IDXW-1:0]));
          check("dfill_we", 32'(dfill_we), 32'(e.kind == 1));
          check("ifill_we", 32'(ifill_we), 32'(e.kind == 2));
          check("dtag_we", 32'(dtag_we), 32'(e.kind == 1 && e.last));
          check("itag_we", 32'(itag_we), 32'(e.kind == 2 && e.last));
          if (e.we) check("wdata", mem_wdata, victim_model(e.addr[IDXW-1:0]));
          else      check("fill_data", fill_data, rdata_model(e.addr));
        end
      end else begin
        check("no_strobe_without_ack", 32'({dfill_we, ifill_we, dtag_we, itag_we}), 32'(0));
      end
      if (dtag_we)  begin n_dtag++; saw_dtag = 1; end
      if (itag_we)  begin n_itag++; saw_itag = 1; end
      if (dfill_we) n_dfill++;
      if (ifill_we) n_ifill++;
      if (mem_req) check("pipe_en_low_in_burst", 32'(pipe_en), 32'(0));
      if (imiss || dmiss) check("pipe_en_low_on_miss", 32'(pipe_en), 32'(0));
      if (prev_hold && mem_req) check("addr_hold_on_stall", 32'(mem_addr), 32'(prev_addr));
      prev_hold = mem_req && !mem_ack;
      prev_addr = mem_addr;
    end
  end

  // One cycle of the cache/memory environment: drop misses after the tag
  // write and drive mem_ack with the configured stall period.
  task automatic step();
    @(posedge clk);
    #1;
    if (saw_dtag) begin dmiss = 0; ddirty = 0; saw_dtag = 0; end
    if (saw_itag) begin imiss = 0; saw_itag = 0; end
    if (mem_req) begin
      if (stall >= period - 1) begin mem_ack = 1; stall = 0; end
      else begin mem_ack = 0; stall++; end
    end else begin
      mem_ack = spurious;
      stall = 0;
    end
  endtask

  task automatic run_until_idle(input string name, input int budget);
    bit ok = 0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (exp_q.size() == 0 && !imiss && !dmiss && !busy) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got busy=%0b pending=%0d, required idle", name, busy, exp_q.size());
    end
  endtask

  initial begin
    vecs[0] = '{"clean_d",    0, 1, 0, 30'h0,     30'h101,      30'h0,        1, 4,  1, 0, 4, 0};
    vecs[1] = '{"dirty_d",    0, 1, 1, 30'h0,     30'h044,      30'h2A0,      1, 8,  1, 0, 4, 0};
    vecs[2] = '{"simult",     1, 1, 0, 30'h010,   30'h080,      30'h0,        1, 8,  1, 1, 4, 4};
    vecs[3] = '{"stall_i",    1, 0, 0, 30'h013,   30'h0,        30'h0,        3, 4,  0, 1, 0, 4};
    vecs[4] = '{"dirty_top",  0, 1, 1, 30'h0,     30'h3FFFFFFE, 30'h3FFFFFFC, 2, 8,  1, 0, 4, 0};
    vecs[5] = '{"dirty_both", 1, 1, 1, 30'h123,   30'h055,      30'h0F0,      1, 12, 1, 1, 4, 4};

    rst_n = 0; imiss = 0; dmiss = 0; ddirty = 0; mem_ack = 0;
    imiss_addr = '0; dmiss_addr = '0; dvictim_addr = '0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_strobes", 32'({dfill_we, ifill_we, dtag_we, itag_we}), 32'(0));
    check("rst_fill_idx", 32'(fill_idx), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_pipe_en", 32'(pipe_en), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    rst_n = 1;

    // Ack with no request outstanding must be ignored.
    spurious = 1;
    repeat (4) step();
    check("spur_fill_idx", 32'(fill_idx), 32'(0));
    check("spur_pipe_en", 32'(pipe_en), 32'(1));
    check("spur_busy", 32'(busy), 32'(0));
    check("spur_mem_req", 32'(mem_req), 32'(0));
    check("spur_acks", 32'(n_acks), 32'(0));
    spurious = 0;
    step();

    foreach (vecs[k]) begin
      clear_counts();
      period = vecs[k].period;
      imiss = vecs[k].im; dmiss = vecs[k].dm; ddirty = vecs[k].dirty;
      imiss_addr = vecs[k].ia; dmiss_addr = vecs[k].da; dvictim_addr = vecs[k].va;
      if (vecs[k].dm && vecs[k].dirty) push_block(0, vecs[k].va);
      if (vecs[k].dm) push_block(1, vecs[k].da);
      if (vecs[k].im) push_block(2, vecs[k].ia);
      run_until_idle(vecs[k].name, 200);
      check({vecs[k].name, "_acks"}, 32'(n_acks), 32'(vecs[k].acks));
      check({vecs[k].name, "_dtag"}, 32'(n_dtag), 32'(vecs[k].dtags));
      check({vecs[k].name, "_itag"}, 32'(n_itag), 32'(vecs[k].itags));
      check({vecs[k].name, "_dfill"}, 32'(n_dfill), 32'(vecs[k].dfills));
      check({vecs[k].name, "_ifill"}, 32'(n_ifill), 32'(vecs[k].ifills));
      check({vecs[k].name, "_pending"}, 32'(exp_q.size()), 32'(0));
      check({vecs[k].name, "_pipe_en"}, 32'(pipe_en), 32'(1));
      exp_q.delete();
      step();
    end

    // Reset in the middle of a D refill, after two words.
    clear_counts();
    period = 1;
    dmiss = 1; ddirty = 0; dmiss_addr = 30'h200;
    push_block(1, 30'h200);
    begin
      bit got2 = 0;
      for (int c = 0; c < 20; c++) begin
        step();
        if (n_acks == 2) begin got2 = 1; break; end
      end
      if (!got2) begin
        checks++;
        failures++;
        $display("FAIL rst_mid_reach: got %0d acks, required 2", n_acks);
      end
    end
    rst_n = 0;
    mem_ack = 0;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_fill_idx", 32'(fill_idx), 32'(0));
    check("rst_mid_no_dtag", 32'(n_dtag), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1;
    exp_q.delete();
    clear_counts();
    push_block(1, 30'h200);
    run_until_idle("rst_restart", 100);
    check("rst_restart_acks", 32'(n_acks), 32'(4));
    check("rst_restart_dtag", 32'(n_dtag), 32'(1));
    check("rst_restart_pipe_en", 32'(pipe_en), 32'(1));

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_refill_ctrl.md
Name: mem_refill_ctrl

Overview:
- Miss-handling controller for the 5-stage MIPS pipeline.
- Shares one main-memory word port between I-cache refills and D-cache writeback/refill.
- Sequences burst transfers word by word and generates the pipeline advance enable (pipe_en), which drives the hit/enable inputs of the IF_ID/ID_EX/EX_MEM/MEM_WB registers.
- Sits between both caches and the memory model.

Parameters:
- WORDS, 4, words per cache block; power of 2, >= 2.
- IDXW, 2, log2(WORDS); width of word-in-block index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imiss  in  1  I-cache miss; held high until the cache reports a hit.
- imiss_addr  in  30  word address of the I-miss.
- dmiss  in  1  D-cache miss; held high until the cache reports a hit.
- dmiss_addr  in  30  word address of the D-miss.
- ddirty  in  1  D victim line is dirty; valid while dmiss is high.
- dvictim_addr  in  30  word address of the D victim block.
- dvictim_data  in  32  victim word selected by fill_idx.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  30  memory word address.
- mem_wdata  out  32  write data, equal to dvictim_data.
- mem_ack  in  1  one word transferred this cycle.
- mem_rdata  in  32  read data, valid when mem_ack is high.
- fill_idx  out  IDXW  current word index in the block.
- fill_data  out  32  equal to mem_rdata.
- ifill_we  out  1  I-cache data word write strobe.
- dfill_we  out  1  D-cache data word write strobe.
- itag_we  out  1  I-cache tag/valid write strobe.
- dtag_we  out  1  D-cache tag/valid write strobe (sets valid, clears dirty).
- pipe_en  out  1  pipeline registers may advance.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, cnt = 0, latched address = 0.
  - All strobes, mem_req and mem_we are 0.
  - pipe_en follows its combinational definition: 1 if no miss is asserted.
- Reset asserted mid-burst aborts the transfer immediately.
  - No tag write occurs for the aborted block.
  - After release, a still-asserted miss restarts from word 0.
- States: IDLE, D_WB, D_FILL, I_FILL, DONE.
- IDLE:
  - dmiss & ddirty -> D_WB.
  - else dmiss -> D_FILL.
  - else imiss -> I_FILL.
  - D has priority over I: it is the older instruction.
  - On the transition, latch the base address (block-aligned, low IDXW bits dropped); set cnt = 0.
- Address generation: mem_addr = {latched_base[29:IDXW], cnt}. Decoded from registered state only.
- D_WB:
  - mem_req = 1, mem_we = 1, base = dvictim_addr.
  - Each mem_ack increments cnt.
  - Ack with cnt == WORDS-1: cnt wraps to 0, latch dmiss_addr base, go to D_FILL.
- D_FILL:
  - mem_req = 1, mem_we = 0.
  - On mem_ack: dfill_we = 1 in that same cycle with fill_idx = cnt; cnt increments.
  - Ack with cnt == WORDS-1: dtag_we = 1 in the same cycle, go to DONE.
- I_FILL: identical to D_FILL, using ifill_we and itag_we.
- DONE:
  - One cycle, no request; go to IDLE. This lets the cache re-evaluate its hit.
  - If imiss is still high in IDLE (simultaneous misses), I_FILL starts the following cycle.
- pipe_en is combinational: (state == IDLE) & ~imiss & ~dmiss.
- Strobes:
  - Fill/tag strobes are single-cycle and combinational from state & mem_ack.
  - mem_ack while mem_req = 0 (IDLE/DONE) is ignored: no count, no strobes.
- mem_ack may stall arbitrarily. mem_req and mem_addr hold stable until ack.
- Miss inputs dropping mid-burst have no effect; the burst completes.
- fill_idx = cnt in every state.

Test Plan:
- Clean D miss: dmiss = 1, dmiss_addr = 0x101, ddirty = 0, ack every cycle.
  -> reads at 0x100..0x103, dfill_we on 4 consecutive cycles with fill_idx 0..3.
  -> dtag_we with the 4th, then DONE.
  -> pipe_en = 1 the cycle after dmiss falls.
- Dirty D miss: ddirty = 1, dvictim_addr = 0x2A0, dmiss_addr = 0x044.
  -> 4 writes at 0x2A0..0x2A3 with mem_wdata = dvictim_data, then 4 reads at 0x044..0x047.
  -> 8 acks total, single dtag_we.
- Simultaneous: imiss = 1 (0x010) and dmiss = 1 (0x080) in the same cycle.
  -> D refill first (0x080..0x083), DONE, IDLE, then I refill 0x010..0x013.
  -> pipe_en low throughout.
- Stalled memory: ack only every 3rd cycle during I_FILL.
  -> mem_addr holds each value 3 cycles; exactly 4 ifill_we pulses.
- Reset mid D_FILL after 2 acks: rst_n = 0 for 1 cycle.
  -> mem_req drops immediately, no dtag_we.
  -> After release with dmiss still high, reads restart at word 0.
- Spurious ack: mem_ack = 1 in IDLE with no miss.
  -> no strobes, cnt stays 0, pipe_en = 1.
